// File: rtl/demux_1to2_reg.sv
// Purpose : registered 1-to-2 demux. One valid/ready input stream is steered to
//           channel 0 or 1 by select_i. Each channel has a one-entry holding
//           register and a wrapping transfer counter.
// Latency : 1 cycle from input fire to dataN_o/validN_o.
// Backpres: ready_o follows only the selected channel: it is high when that
//           channel is empty or draining this cycle. No head-of-line coupling.
// Ports   : clk_i, rst_i (async, active-high)
//           data_i/select_i/valid_i/ready_o  input stream
//           data0_o/valid0_o/ready0_i        channel 0 output stream
//           data1_o/valid1_o/ready1_i        channel 1 output stream
//           count0_o/count1_o                completed output transfers per channel
module demux_1to2_reg #(
  parameter int size  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [size-1:0]  data_i,
  input  logic             select_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [size-1:0]  data0_o,
  output logic             valid0_o,
  input  logic             ready0_i,
  output logic [size-1:0]  data1_o,
  output logic             valid1_o,
  input  logic             ready1_i,
  output logic [CNT_W-1:0] count0_o,
  output logic [CNT_W-1:0] count1_o
);

  logic [size-1:0]  data0_q, data0_d;
  logic [size-1:0]  data1_q, data1_d;
  logic             valid0_q, valid0_d;
  logic             valid1_q, valid1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic fire_in;
  logic load0, load1;
  logic fire0, fire1;

  // A full channel can still accept when its consumer takes the held beat in
  // the same cycle, which keeps throughput at one beat per cycle.
  assign ready_o = select_i ? (~valid1_q | ready1_i) : (~valid0_q | ready0_i);

  assign fire_in = valid_i & ready_o;
  assign load0   = fire_in & ~select_i;
  assign load1   = fire_in &  select_i;
  assign fire0   = valid0_q & ready0_i;
  assign fire1   = valid1_q & ready1_i;

  always_comb begin
    data0_d  = data0_q;
    data1_d  = data1_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;

    // Load takes priority over drain: a simultaneous fire and load replaces
    // the held beat and the channel stays full.
    if (load0) begin
      data0_d  = data_i;
      valid0_d = 1'b1;
    end else if (fire0) begin
      valid0_d = 1'b0;
    end

    if (load1) begin
      data1_d  = data_i;
      valid1_d = 1'b1;
    end else if (fire1) begin
      valid1_d = 1'b0;
    end

    if (fire0) cnt0_d = cnt0_q + CNT_W'(1);
    if (fire1) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data0_q  <= '0;
      data1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign data0_o  = data0_q;
  assign data1_o  = data1_q;
  assign valid0_o = valid0_q;
  assign valid1_o = valid1_q;
  assign count0_o = cnt0_q;
  assign count1_o = cnt1_q;

endmodule

// File: tb/tb_demux_1to2_reg.sv
module tb_demux_1to2_reg;
  localparam int W  = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          rst, valid, sel, rdy0, rdy1, ready_o;
  logic [W-1:0]  din, data0_o, data1_o;
  logic          valid0_o, valid1_o;
  logic [CW-1:0] count0_o, count1_o;

  demux_1to2_reg #(.size(W), .CNT_W(CW)) u_dut (
    .clk_i(clk), .rst_i(rst), .data_i(din), .select_i(sel), .valid_i(valid),
    .ready_o(ready_o), .data0_o(data0_o), .valid0_o(valid0_o), .ready0_i(rdy0),
    .data1_o(data1_o), .valid1_o(valid1_o), .ready1_i(rdy1),
    .count0_o(count0_o), .count1_o(count1_o)
  );

  // narrow-counter instance for the wrap check
  logic       w_rst, w_valid, w_sel, w_rdy0, w_rdy1, w_ready;
  logic [3:0] w_din, w_data0, w_data1;
  logic       w_valid0, w_valid1;
  logic [1:0] w_count0, w_count1;

  demux_1to2_reg #(.size(4), .CNT_W(2)) u_wrap (
    .clk_i(clk), .rst_i(w_rst), .data_i(w_din), .select_i(w_sel), .valid_i(w_valid),
    .ready_o(w_ready), .data0_o(w_data0), .valid0_o(w_valid0), .ready0_i(w_rdy0),
    .data1_o(w_data1), .valid1_o(w_valid1), .ready1_i(w_rdy1),
    .count0_o(w_count0), .count1_o(w_count1)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: each channel is a list of accepted-but-undelivered beats,
  // plus the last loaded value (what dataN_o shows) and a delivery count
  logic [W-1:0] q0[$], q1[$];
  logic [W-1:0] last0, last1;
  int           cnt0, cnt1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0;
    cnt0 = 0; cnt1 = 0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ":valid0"}, 64'(valid0_o), 64'(q0.size() != 0));
    chk({ph, ":valid1"}, 64'(valid1_o), 64'(q1.size() != 0));
    chk({ph, ":data0"},  64'(data0_o),  64'(last0));
    chk({ph, ":data1"},  64'(data1_o),  64'(last1));
    chk({ph, ":count0"}, 64'(count0_o), 64'(cnt0 % (1 << CW)));
    chk({ph, ":count1"}, 64'(count1_o), 64'(cnt1 % (1 << CW)));
  endtask

  // one clock cycle: drive, check combinational ready, advance model, check outputs
  task automatic cycle(input string ph, input logic v, input logic s,
                       input logic [W-1:0] d, input logic r0, input logic r1);
    logic er, fin, f0, f1;
    valid = v; sel = s; din = d; rdy0 = r0; rdy1 = r1;
    #1;
    er = s ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
    chk({ph, ":ready_o"}, 64'(ready_o), 64'(er));
    fin = v && er;
    f0  = (q0.size() != 0) && r0;
    f1  = (q1.size() != 0) && r1;
    @(posedge clk);
    if (f0) begin void'(q0.pop_front()); cnt0++; end
    if (f1) begin void'(q1.pop_front()); cnt1++; end
    if (fin) begin
      if (s) begin q1.push_back(d); last1 = d; end
      else   begin q0.push_back(d); last0 = d; end
    end
    #1;
    check_outputs(ph);
  endtask

  initial begin
    logic [1:0] wrap_exp [5];
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    rst = 1'b1; valid = 1'b0; sel = 1'b0; din = '0; rdy0 = 1'b0; rdy1 = 1'b0;
    w_rst = 1'b1; w_valid = 1'b0; w_sel = 1'b0; w_din = '0; w_rdy0 = 1'b0; w_rdy1 = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    rst = 1'b0;

    // back-to-back streaming into channel 0
    for (int i = 0; i < 4; i++) cycle("stream", 1'b1, 1'b0, W'(32'hA0 + i), 1'b1, 1'b0);
    cycle("stream_drain", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("stream_count0", 64'(count0_o), 64'd4);

    // backpressure on channel 1
    cycle("bp_load", 1'b1, 1'b1, W'(32'h55), 1'b1, 1'b0);
    cycle("bp_stall", 1'b1, 1'b1, W'(32'h66), 1'b1, 1'b0);
    chk("bp_hold_data1", 64'(data1_o), 64'h55);
    cycle("bp_replace", 1'b1, 1'b1, W'(32'h66), 1'b1, 1'b1);
    chk("bp_data1", 64'(data1_o), 64'h66);
    chk("bp_count1", 64'(count1_o), 64'd1);
    cycle("bp_drain", 1'b0, 1'b1, '0, 1'b1, 1'b1);

    // channel 0 blocked must not stall channel 1
    cycle("nc_load0", 1'b1, 1'b0, W'(32'h33), 1'b0, 1'b0);
    cycle("nc_load1", 1'b1, 1'b1, W'(32'h77), 1'b0, 1'b0);
    chk("nc_data1", 64'(data1_o), 64'h77);
    chk("nc_data0", 64'(data0_o), 64'h33);

    // asynchronous reset with channel 0 full, checked before any clock edge
    valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid0", 64'(valid0_o), 64'd0);
    chk("arst_count0", 64'(count0_o), 64'd0);
    chk("arst_data0",  64'(data0_o),  64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle("post_reset", 1'b0, 1'b0, '0, 1'b1, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    for (int i = 0; i < 3; i++) cycle("rand_drain", 1'b0, 1'b0, '0, 1'b1, 1'b1);

    // counter wrap on the 2-bit instance: five fires on channel 1
    @(negedge clk);
    w_rst = 1'b0;
    w_sel = 1'b1; w_rdy1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w_valid = (i < 5);
      w_din   = 4'(i + 1);
      @(posedge clk);
      #1;
      if (i >= 1) chk($sformatf("wrap_count1_%0d", i), 64'(w_count1), 64'(wrap_exp[i-1]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
